dispatch_stage: RTL and testbench
=================================

# dispatch_stage

Registered, back-pressured dispatch stage between decode and the four issue queues (int, mult, div, ld/st). Captures one decoded instruction in a holding register, resolves operand validity (x0, tag-pending flag, multi-port CDB snoop at capture and while held), routes it to exactly one queue, and stalls on queue-full. An internal branch-shadow FSM replaces the external branch-stall one-shot pulses.

## Interface
Parameters:
- CDB_PORTS, 1, number of CDB broadcast ports snooped.
- BR_SHADOW, 2, instructions allowed to dispatch after a branch/JALR before dispatch blocks until resolution (0 = block immediately).
- MULDIV_EN, 1, 1: MUL/DIV go to the mult/div queues; 0: they go to the int queue.

Ports (XLEN=32, TAG_W=6 from package):
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush; empties holding register, FSM to IDLE.
- br_resolved  in  1  outstanding branch resolved.
- dec_valid  in  1  decode offers an instruction.
- dec_ready  out  1  stage accepts this cycle.
- rs1, rs2  in  5  source register indices.
- rs1_data, rs2_data  in  XLEN  register-file/RAT data.
- rs1_tag, rs2_tag  in  TAG_W+1  bit TAG_W = pending; [TAG_W-1:0] = ROB tag.
- rd_tag  in  TAG_W  destination tag.
- opcode  in  7; func3  in  3; func7  in  7; immediate  in  XLEN.
- cdb_valid  in  CDB_PORTS; cdb_tag  in  CDB_PORTS*TAG_W; cdb_data  in  CDB_PORTS*XLEN.
- queue_full  in  4  [0]=int [1]=mult [2]=div [3]=ld/st.
- dispatch_en  out  4  one-hot write pulse, same indexing.
- o_int_fifo_data  out  int_fifo_data; o_mult_fifo_data, o_div_fifo_data  out  common_fifo_data; o_ld_st_fifo_data  out  ld_st_fifo_data.

## Operation
- Capture (accept = dec_valid & dec_ready): register rs1/rs2 data/tag, rd_tag, opcode, func3, func7, immediate, computed target queue, held_valid=1.
- Operand valid at capture: rs==0 -> valid; else tag pending and any cdb_valid[i] with cdb_tag[i]==tag -> valid, data=cdb_data[i] (lowest i wins); else valid = ~tag[TAG_W].
- I_TYPE, LUI_TYPE: rs2_data=immediate, rs2_valid=1. LOAD_TYPE: rs2_valid=1.
- While held and operand not valid: same CDB match updates data and sets valid each cycle.
- Routing: R_TYPE func7=1,func3=0 -> mult; func7=1,func3=4 -> div (both int if MULDIV_EN=0); other R, I, BRANCH, JALR, LUI, AUIPC -> int; LOAD, STORE -> ld/st; J_TYPE and unknown -> none (consumed, no pulse).
- Fire = held_valid & (target none | ~queue_full[target]) & branch gate. dispatch_en[target] = fire for that target. Held cleared on fire unless refilled.
- dec_ready = ~rst & (~held_valid | fire) & (state != BLOCK).
- ld_st_opcode = (opcode==STORE_TYPE). Outputs driven from holding register.
- Branch FSM: IDLE -> SHADOW (cnt=0) on fire of BRANCH/JALR; SHADOW: each fire cnt++, cnt==BR_SHADOW -> BLOCK (BR_SHADOW=0: IDLE -> BLOCK directly). Any state -> IDLE on br_resolved. A BRANCH/JALR held while not IDLE does not fire (branch gate). flush: held_valid=0, IDLE, cnt=0; flush wins over accept in the same cycle.

## Timing
- Reset: held_valid=0, dispatch_en=0, dec_ready=0 during rst, FSM IDLE, cnt=0, all payload outputs 0.
- Latency: accept at cycle N -> dispatch_en earliest cycle N+1. Throughput 1/cycle with queues not full.
- Full target: instruction held, dec_ready=0, dispatch_en=0 until full drops; fires same cycle full deasserts.
- CDB match in a fire cycle is not reflected on outputs; queues snoop that cycle themselves.
- br_resolved with fire of a new branch same cycle: new branch takes FSM to SHADOW/BLOCK (resolve applies to old branch).

## Structure
- utils package: opcode localparams, XLEN, TAG_W, common_fifo_data/int_fifo_data/ld_st_fifo_data typedefs, queue index localparams Q_INT/Q_MULT/Q_DIV/Q_LDST, branch FSM state enum.
- One sub-module: cdb_snoop (per-operand CDB_PORTS tag-compare/mux returning hit and data), instantiated twice at capture and twice on held operands.

## Test plan
- ADD x3,x1,x2, rs1_tag=7'h45 pending, no CDB, queues empty -> next cycle dispatch_en=4'b0001, rs1_valid=0, rs1_tag=5, rs2_valid per tag.
- MUL held with queue_full[1]=1 for 3 cycles -> dispatch_en=0, dec_ready=0 three cycles; fires 4'b0010 on the cycle full drops.
- Held ADD rs1 tag 5 pending, CDB_PORTS=2, cdb_valid=2'b10, cdb_tag[1]=5, data 32'hDEADBEEF -> later dispatch shows rs1_valid=1, rs1_data=32'hDEADBEEF.
- BEQ then 3 ADDs, BR_SHADOW=2 -> BEQ + 2 ADDs dispatch, dec_ready=0 after; br_resolved -> third ADD accepted, dispatched next cycle.
- ADDI x5,x0,-1 -> rs1_valid=1, rs2_data=32'hFFFFFFFF, rs2_valid=1, int pulse; SW -> 4'b1000, ld_st_opcode=1; JAL -> no pulse, dec_ready stays 1.
- flush while held LW and in BLOCK -> next cycle held empty, FSM IDLE, no dispatch_en; rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/dispatch_stage_pkg.sv
// Shared types and constants for the decode-to-issue dispatch stage.
// Latency: n/a (types, constants and a pure routing function only).
// Backpressure: n/a.
package dispatch_stage_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    // RV32 major opcodes recognised by the dispatcher
    localparam logic [6:0] R_TYPE      = 7'b0110011;
    localparam logic [6:0] I_TYPE      = 7'b0010011;
    localparam logic [6:0] LOAD_TYPE   = 7'b0000011;
    localparam logic [6:0] STORE_TYPE  = 7'b0100011;
    localparam logic [6:0] BRANCH_TYPE = 7'b1100011;
    localparam logic [6:0] JALR_TYPE   = 7'b1100111;
    localparam logic [6:0] J_TYPE      = 7'b1101111;
    localparam logic [6:0] LUI_TYPE    = 7'b0110111;
    localparam logic [6:0] AUIPC_TYPE  = 7'b0010111;

    // Bit positions in queue_full / dispatch_en
    localparam int Q_INT  = 0;
    localparam int Q_MULT = 1;
    localparam int Q_DIV  = 2;
    localparam int Q_LDST = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHADOW = 2'd1,
        ST_BLOCK  = 2'd2
    } br_state_e;

    typedef struct packed {
        logic [XLEN-1:0]  rs1_data;
        logic [TAG_W-1:0] rs1_tag;
        logic             rs1_valid;
        logic [XLEN-1:0]  rs2_data;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs2_valid;
        logic [TAG_W-1:0] rd_tag;
    } common_fifo_data;

    typedef struct packed {
        common_fifo_data  common;
        logic [6:0]       opcode;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [XLEN-1:0]  immediate;
    } int_fifo_data;

    typedef struct packed {
        common_fifo_data  common;
        logic [XLEN-1:0]  immediate;
        logic [2:0]       func3;
        logic             ld_st_opcode;
    } ld_st_fifo_data;

    // One-hot issue-queue select; all-zero means consumed without dispatch.
    function automatic logic [3:0] route_target(input logic [6:0] opcode,
                                                input logic [2:0] func3,
                                                input logic [6:0] func7,
                                                input bit         muldiv_en);
        logic [3:0] tgt;
        tgt = 4'b0000;
        case (opcode)
            R_TYPE: begin
                if (muldiv_en && func7 == 7'd1 && func3 == 3'd0) begin
                    tgt[Q_MULT] = 1'b1;
                end else if (muldiv_en && func7 == 7'd1 && func3 == 3'd4) begin
                    tgt[Q_DIV] = 1'b1;
                end else begin
                    tgt[Q_INT] = 1'b1;
                end
            end
            I_TYPE, BRANCH_TYPE, JALR_TYPE, LUI_TYPE, AUIPC_TYPE: tgt[Q_INT] = 1'b1;
            LOAD_TYPE, STORE_TYPE:                                tgt[Q_LDST] = 1'b1;
            default:                                              tgt = 4'b0000;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/dispatch_stage_cdb_snoop.sv
// Compares one operand tag against every CDB port and returns the broadcast data.
// Latency: purely combinational.
// Backpressure: none; the lowest-numbered matching port wins.
module dispatch_stage_cdb_snoop
    import dispatch_stage_pkg::*;
#(
    parameter int CDB_PORTS = 1
) (
    input  logic [TAG_W-1:0]           tag_i,
    input  logic [CDB_PORTS-1:0]       cdb_valid_i,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag_i,
    input  logic [CDB_PORTS*XLEN-1:0]  cdb_data_i,
    output logic                       hit_o,
    output logic [XLEN-1:0]            data_o
);

    // Scan from the top port down so a lower-numbered match overrides a higher one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int i = CDB_PORTS - 1; i >= 0; i--) begin
            if (cdb_valid_i[i] && (cdb_tag_i[i*TAG_W +: TAG_W] == tag_i)) begin
                hit_o  = 1'b1;
                data_o = cdb_data_i[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// Holds one decoded instruction, resolves operands via CDB snoop, routes it to one issue queue.
// Latency: accept in cycle N, dispatch_en earliest in cycle N+1; one instruction per cycle.
// Backpressure: target queue full or branch-shadow block holds the instruction and drops dec_ready.
module dispatch_stage
    import dispatch_stage_pkg::*;
#(
    parameter int CDB_PORTS = 1,
    parameter int BR_SHADOW = 2,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       br_resolved,
    input  logic                       dec_valid,
    output logic                       dec_ready,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [XLEN-1:0]            rs1_data,
    input  logic [XLEN-1:0]            rs2_data,
    input  logic [TAG_W:0]             rs1_tag,
    input  logic [TAG_W:0]             rs2_tag,
    input  logic [TAG_W-1:0]           rd_tag,
    input  logic [6:0]                 opcode,
    input  logic [2:0]                 func3,
    input  logic [6:0]                 func7,
    input  logic [XLEN-1:0]            immediate,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]  cdb_data,
    input  logic [3:0]                 queue_full,
    output logic [3:0]                 dispatch_en,
    output int_fifo_data               o_int_fifo_data,
    output common_fifo_data            o_mult_fifo_data,
    output common_fifo_data            o_div_fifo_data,
    output ld_st_fifo_data             o_ld_st_fifo_data
);

    localparam int CNT_W = (BR_SHADOW < 1) ? 1 : $clog2(BR_SHADOW + 1);

    logic            held_q, held_d;
    common_fifo_data cmn_q, cmn_d, cap_cmn, upd_cmn;
    logic [6:0]      opcode_q, opcode_d, func7_q, func7_d;
    logic [2:0]      func3_q, func3_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [3:0]      tgt_q, tgt_d;
    br_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            c1_hit, c2_hit, h1_hit, h2_hit;
    logic [XLEN-1:0] c1_data, c2_data, h1_data, h2_data;
    logic            fsm_block, fsm_busy, is_br_q, fire, accept;

    dispatch_stage_cdb_snoop #(.CDB_PORTS(CDB_PORTS)) u_snoop_cap1 (
        .tag_i(rs1_tag[TAG_W-1:0]), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_data_i(cdb_data), .hit_o(c1_hit), .data_o(c1_data));
    dispatch_stage_cdb_snoop #(.CDB_PORTS(CDB_PORTS)) u_snoop_cap2 (
        .tag_i(rs2_tag[TAG_W-1:0]), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_data_i(cdb_data), .hit_o(c2_hit), .data_o(c2_data));
    dispatch_stage_cdb_snoop #(.CDB_PORTS(CDB_PORTS)) u_snoop_held1 (
        .tag_i(cmn_q.rs1_tag), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_data_i(cdb_data), .hit_o(h1_hit), .data_o(h1_data));
    dispatch_stage_cdb_snoop #(.CDB_PORTS(CDB_PORTS)) u_snoop_held2 (
        .tag_i(cmn_q.rs2_tag), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
        .cdb_data_i(cdb_data), .hit_o(h2_hit), .data_o(h2_data));

    // A branch waiting behind an outstanding branch, or anything in BLOCK, must not issue.
    assign is_br_q   = (opcode_q == BRANCH_TYPE) || (opcode_q == JALR_TYPE);
    assign fire      = ~rst & held_q & ((tgt_q & queue_full) == 4'b0000)
                       & ~fsm_block & ~(is_br_q & fsm_busy);
    assign dec_ready = ~rst & (~held_q | fire) & ~fsm_block;
    assign accept    = dec_valid & dec_ready;
    assign dispatch_en = fire ? tgt_q : 4'b0000;

    // Operand resolution for the incoming instruction: x0, then CDB forward, then tag pending bit.
    always_comb begin
        cap_cmn          = '0;
        cap_cmn.rd_tag   = rd_tag;
        cap_cmn.rs1_tag  = rs1_tag[TAG_W-1:0];
        cap_cmn.rs2_tag  = rs2_tag[TAG_W-1:0];
        cap_cmn.rs1_data = rs1_data;
        cap_cmn.rs2_data = rs2_data;
        if (rs1 == 5'd0) begin
            cap_cmn.rs1_valid = 1'b1;
        end else if (rs1_tag[TAG_W] && c1_hit) begin
            cap_cmn.rs1_valid = 1'b1;
            cap_cmn.rs1_data  = c1_data;
        end else begin
            cap_cmn.rs1_valid = ~rs1_tag[TAG_W];
        end
        if (rs2 == 5'd0) begin
            cap_cmn.rs2_valid = 1'b1;
        end else if (rs2_tag[TAG_W] && c2_hit) begin
            cap_cmn.rs2_valid = 1'b1;
            cap_cmn.rs2_data  = c2_data;
        end else begin
            cap_cmn.rs2_valid = ~rs2_tag[TAG_W];
        end
        // Immediate forms carry the immediate as operand 2; loads have no second source.
        if (opcode == I_TYPE || opcode == LUI_TYPE) begin
            cap_cmn.rs2_data  = immediate;
            cap_cmn.rs2_valid = 1'b1;
        end else if (opcode == LOAD_TYPE) begin
            cap_cmn.rs2_valid = 1'b1;
        end
    end

    // Held operands still waiting on a producer pick up a CDB broadcast every cycle.
    always_comb begin
        upd_cmn = cmn_q;
        if (!cmn_q.rs1_valid && h1_hit) begin
            upd_cmn.rs1_valid = 1'b1;
            upd_cmn.rs1_data  = h1_data;
        end
        if (!cmn_q.rs2_valid && h2_hit) begin
            upd_cmn.rs2_valid = 1'b1;
            upd_cmn.rs2_data  = h2_data;
        end
    end

    // Holding register next state: flush beats a refill, a refill beats a plain drain.
    always_comb begin
        held_d   = held_q;
        cmn_d    = upd_cmn;
        opcode_d = opcode_q;
        func3_d  = func3_q;
        func7_d  = func7_q;
        imm_d    = imm_q;
        tgt_d    = tgt_q;
        if (flush) begin
            held_d = 1'b0;
        end else if (accept) begin
            held_d   = 1'b1;
            cmn_d    = cap_cmn;
            opcode_d = opcode;
            func3_d  = func3;
            func7_d  = func7;
            imm_d    = immediate;
            tgt_d    = route_target(opcode, func3, func7, MULDIV_EN);
        end else if (fire) begin
            held_d = 1'b0;
        end
    end

    // Holding register and branch FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q   <= 1'b0;
            cmn_q    <= '0;
            opcode_q <= '0;
            func3_q  <= '0;
            func7_q  <= '0;
            imm_q    <= '0;
            tgt_q    <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
        end else begin
            held_q   <= held_d;
            cmn_q    <= cmn_d;
            opcode_q <= opcode_d;
            func3_q  <= func3_d;
            func7_q  <= func7_d;
            imm_q    <= imm_d;
            tgt_q    <= tgt_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    // Branch-shadow next state; a newly issued branch outranks a resolve for the older one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (fire && is_br_q) begin
            state_d = (BR_SHADOW == 0) ? ST_BLOCK : ST_SHADOW;
            cnt_d   = '0;
        end else if (br_resolved) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (fire && state_q == ST_SHADOW) begin
            if (cnt_q == CNT_W'(BR_SHADOW - 1)) begin
                state_d = ST_BLOCK;
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // FSM outputs: BLOCK stops everything, any non-IDLE state holds back further branches.
    always_comb begin
        fsm_block = (state_q == ST_BLOCK);
        fsm_busy  = (state_q != ST_IDLE);
    end

    // Every queue sees the same holding-register contents; only dispatch_en selects.
    always_comb begin
        o_int_fifo_data.common    = cmn_q;
        o_int_fifo_data.opcode    = opcode_q;
        o_int_fifo_data.func3     = func3_q;
        o_int_fifo_data.func7     = func7_q;
        o_int_fifo_data.immediate = imm_q;
        o_mult_fifo_data          = cmn_q;
        o_div_fifo_data           = cmn_q;
        o_ld_st_fifo_data.common       = cmn_q;
        o_ld_st_fifo_data.immediate    = imm_q;
        o_ld_st_fifo_data.func3        = func3_q;
        o_ld_st_fifo_data.ld_st_opcode = (opcode_q == STORE_TYPE);
    end

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed plus randomized bench for dispatch_stage against a transaction-level reference.
// Latency: reference predicts each cycle's dec_ready, dispatch_en and dispatched payload.
// Backpressure: queue_full, branch shadow, flush and reset are all driven.
module tb_dispatch_stage;
    import dispatch_stage_pkg::*;

    localparam int CDB_PORTS = 2;
    localparam int BR_SHADOW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, flush = 1'b0, br_resolved = 1'b0, dec_valid = 1'b0, dec_ready;
    logic [4:0] rs1 = '0, rs2 = '0;
    logic [XLEN-1:0] rs1_data = '0, rs2_data = '0, immediate = '0;
    logic [TAG_W:0] rs1_tag = '0, rs2_tag = '0;
    logic [TAG_W-1:0] rd_tag = '0;
    logic [6:0] opcode = '0, func7 = '0;
    logic [2:0] func3 = '0;
    logic [CDB_PORTS-1:0] cdb_valid = '0;
    logic [CDB_PORTS*TAG_W-1:0] cdb_tag = '0;
    logic [CDB_PORTS*XLEN-1:0] cdb_data = '0;
    logic [3:0] queue_full = '0, dispatch_en;
    int_fifo_data o_int_fifo_data;
    common_fifo_data o_mult_fifo_data, o_div_fifo_data;
    ld_st_fifo_data o_ld_st_fifo_data;

    dispatch_stage #(.CDB_PORTS(CDB_PORTS), .BR_SHADOW(BR_SHADOW), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .br_resolved(br_resolved),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rd_tag(rd_tag), .opcode(opcode), .func3(func3), .func7(func7), .immediate(immediate),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .queue_full(queue_full), .dispatch_en(dispatch_en),
        .o_int_fifo_data(o_int_fifo_data), .o_mult_fifo_data(o_mult_fifo_data),
        .o_div_fifo_data(o_div_fifo_data), .o_ld_st_fifo_data(o_ld_st_fifo_data));

    int vectors = 0;
    int miscompares = 0;

    // Reference view of the stage: the held instruction plus "branch outstanding" bookkeeping.
    typedef struct {
        logic [31:0] d1, d2, imm;
        logic [5:0]  t1, t2, rd;
        logic        v1, v2;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
    } ins_t;

    bit   m_held = 0;
    ins_t m_ins;
    int   m_tgt = -1;
    bit   m_br_out = 0;
    int   m_after = 0;
    logic [6:0] op_tab [11];

    task automatic chk(input string name, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int model_route(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        if (op == R_TYPE && f7 == 7'd1 && f3 == 3'd0) return 1;
        if (op == R_TYPE && f7 == 7'd1 && f3 == 3'd4) return 2;
        if (op == R_TYPE || op == I_TYPE || op == BRANCH_TYPE || op == JALR_TYPE ||
            op == LUI_TYPE || op == AUIPC_TYPE) return 0;
        if (op == LOAD_TYPE || op == STORE_TYPE) return 3;
        return -1;
    endfunction

    function automatic int cdb_port(input logic [5:0] tag);
        for (int i = 0; i < CDB_PORTS; i++)
            if (cdb_valid[i] && cdb_tag[i*TAG_W +: TAG_W] == tag) return i;
        return -1;
    endfunction

    task automatic model_eval(output bit fire, output bit rdy, output logic [3:0] en);
        bit is_br, blocked;
        is_br   = (m_ins.op == BRANCH_TYPE) || (m_ins.op == JALR_TYPE);
        blocked = m_br_out && (m_after >= BR_SHADOW);
        fire = !rst && m_held && !blocked && !(is_br && m_br_out) &&
               (m_tgt < 0 || !queue_full[m_tgt]);
        rdy  = !rst && (!m_held || fire) && !blocked;
        en   = (fire && m_tgt >= 0) ? (4'b0001 << m_tgt) : 4'b0000;
    endtask

    task automatic check_payload();
        common_fifo_data c;
        int_fifo_data    ei;
        ld_st_fifo_data  el;
        c.rs1_data = m_ins.d1; c.rs1_tag = m_ins.t1; c.rs1_valid = m_ins.v1;
        c.rs2_data = m_ins.d2; c.rs2_tag = m_ins.t2; c.rs2_valid = m_ins.v2;
        c.rd_tag = m_ins.rd;
        ei.common = c; ei.opcode = m_ins.op; ei.func3 = m_ins.f3; ei.func7 = m_ins.f7;
        ei.immediate = m_ins.imm;
        el.common = c; el.immediate = m_ins.imm; el.func3 = m_ins.f3;
        el.ld_st_opcode = (m_ins.op == STORE_TYPE);
        case (m_tgt)
            0: chk("int_payload", 160'(o_int_fifo_data), 160'(ei));
            1: chk("mult_payload", 160'(o_mult_fifo_data), 160'(c));
            2: chk("div_payload", 160'(o_div_fifo_data), 160'(c));
            default: chk("ldst_payload", 160'(o_ld_st_fifo_data), 160'(el));
        endcase
    endtask

    task automatic model_next(input bit fire, input bit rdy);
        bit is_br;
        int p;
        is_br = (m_ins.op == BRANCH_TYPE) || (m_ins.op == JALR_TYPE);
        if (rst || flush) begin
            m_held = 0; m_br_out = 0; m_after = 0;
        end else begin
            if (fire && is_br) begin
                m_br_out = 1; m_after = 0;
            end else if (br_resolved) begin
                m_br_out = 0; m_after = 0;
            end else if (fire && m_br_out) begin
                m_after++;
            end
            if (m_held && !m_ins.v1) begin
                p = cdb_port(m_ins.t1);
                if (p >= 0) begin m_ins.v1 = 1; m_ins.d1 = cdb_data[p*XLEN +: XLEN]; end
            end
            if (m_held && !m_ins.v2) begin
                p = cdb_port(m_ins.t2);
                if (p >= 0) begin m_ins.v2 = 1; m_ins.d2 = cdb_data[p*XLEN +: XLEN]; end
            end
            if (dec_valid && rdy) begin
                m_held = 1;
                m_ins.op = opcode; m_ins.f3 = func3; m_ins.f7 = func7; m_ins.imm = immediate;
                m_ins.rd = rd_tag; m_ins.t1 = rs1_tag[5:0]; m_ins.t2 = rs2_tag[5:0];
                m_ins.d1 = rs1_data; m_ins.d2 = rs2_data;
                p = cdb_port(rs1_tag[5:0]);
                if (rs1 == 0) m_ins.v1 = 1;
                else if (rs1_tag[6] && p >= 0) begin m_ins.v1 = 1; m_ins.d1 = cdb_data[p*XLEN +: XLEN]; end
                else m_ins.v1 = !rs1_tag[6];
                p = cdb_port(rs2_tag[5:0]);
                if (rs2 == 0) m_ins.v2 = 1;
                else if (rs2_tag[6] && p >= 0) begin m_ins.v2 = 1; m_ins.d2 = cdb_data[p*XLEN +: XLEN]; end
                else m_ins.v2 = !rs2_tag[6];
                if (opcode == I_TYPE || opcode == LUI_TYPE) begin
                    m_ins.d2 = immediate; m_ins.v2 = 1;
                end else if (opcode == LOAD_TYPE) begin
                    m_ins.v2 = 1;
                end
                m_tgt = model_route(opcode, func3, func7);
            end else if (fire) begin
                m_held = 0;
            end
        end
    endtask

    // One clock: compare this cycle's outputs with the reference, then advance both.
    task automatic tick();
        bit f, r;
        logic [3:0] e;
        #2;
        model_eval(f, r, e);
        chk("dec_ready", 160'(dec_ready), 160'(r));
        chk("dispatch_en", 160'(dispatch_en), 160'(e));
        if (e != 4'b0000) check_payload();
        model_next(f, r);
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [6:0] t1, input logic [6:0] t2, input logic [31:0] imm);
        dec_valid = 1'b1; opcode = op; func3 = f3; func7 = f7; rs1 = r1; rs2 = r2;
        rs1_tag = t1; rs2_tag = t2; immediate = imm;
        rs1_data = $urandom; rs2_data = $urandom; rd_tag = 6'($urandom);
    endtask

    initial begin
        op_tab = '{R_TYPE, R_TYPE, I_TYPE, LOAD_TYPE, STORE_TYPE, BRANCH_TYPE,
                   JALR_TYPE, J_TYPE, LUI_TYPE, AUIPC_TYPE, 7'h7F};
        m_ins = '{default: '0};
        @(posedge clk); #1;
        repeat (3) tick();
        chk("rst_int_zero", 160'(o_int_fifo_data), 160'(0));
        chk("rst_ldst_zero", 160'(o_ld_st_fifo_data), 160'(0));
        rst = 1'b0;

        // ADD with rs1 pending on tag 5
        offer(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 7'h45, 7'h07, 32'd0);
        tick();
        dec_valid = 1'b0;
        #2;
        chk("add_en", 160'(dispatch_en), 160'(4'b0001));
        chk("add_rs1_valid", 160'(o_int_fifo_data.common.rs1_valid), 160'(1'b0));
        chk("add_rs1_tag", 160'(o_int_fifo_data.common.rs1_tag), 160'(6'd5));
        chk("add_rs2_valid", 160'(o_int_fifo_data.common.rs2_valid), 160'(1'b1));
        tick();

        // MUL stalled three cycles on a full mult queue
        queue_full = 4'b0010;
        offer(R_TYPE, 3'd0, 7'd1, 5'd3, 5'd4, 7'h01, 7'h02, 32'd0);
        tick();
        offer(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 7'h01, 7'h02, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mul_stall_en", 160'(dispatch_en), 160'(4'b0000));
            chk("mul_stall_rdy", 160'(dec_ready), 160'(1'b0));
            tick();
        end
        queue_full = 4'b0000;
        #2;
        chk("mul_release_en", 160'(dispatch_en), 160'(4'b0010));
        tick();
        dec_valid = 1'b0;
        tick();

        // Held ADD picks up its operand from CDB port 1
        queue_full = 4'b0001;
        offer(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 7'h45, 7'h03, 32'd0);
        tick();
        dec_valid = 1'b0;
        cdb_valid = 2'b10;
        cdb_tag   = {6'd5, 6'd9};
        cdb_data  = {32'hDEADBEEF, 32'h12345678};
        tick();
        cdb_valid = 2'b00;
        queue_full = 4'b0000;
        #2;
        chk("cdb_rs1_valid", 160'(o_int_fifo_data.common.rs1_valid), 160'(1'b1));
        chk("cdb_rs1_data", 160'(o_int_fifo_data.common.rs1_data), 160'(32'hDEADBEEF));
        tick();

        // BEQ then three ADDs with a two-deep shadow
        offer(BRANCH_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 7'h01, 7'h02, 32'd16);
        tick();
        offer(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 7'h01, 7'h02, 32'd0);
        repeat (3) tick();
        dec_valid = 1'b0;
        #2;
        chk("shadow_block_rdy", 160'(dec_ready), 160'(1'b0));
        chk("shadow_block_en", 160'(dispatch_en), 160'(4'b0000));
        tick();
        br_resolved = 1'b1;
        tick();
        br_resolved = 1'b0;
        #2;
        chk("resolve_en", 160'(dispatch_en), 160'(4'b0001));
        tick();

        // ADDI x5,x0,-1 ; SW ; JAL
        offer(I_TYPE, 3'd0, 7'd0, 5'd0, 5'd0, 7'h4A, 7'h4B, 32'hFFFFFFFF);
        tick();
        offer(STORE_TYPE, 3'd2, 7'd0, 5'd2, 5'd3, 7'h01, 7'h02, 32'd8);
        #2;
        chk("addi_en", 160'(dispatch_en), 160'(4'b0001));
        chk("addi_rs1_valid", 160'(o_int_fifo_data.common.rs1_valid), 160'(1'b1));
        chk("addi_rs2_data", 160'(o_int_fifo_data.common.rs2_data), 160'(32'hFFFFFFFF));
        chk("addi_rs2_valid", 160'(o_int_fifo_data.common.rs2_valid), 160'(1'b1));
        tick();
        offer(J_TYPE, 3'd0, 7'd0, 5'd0, 5'd0, 7'h00, 7'h00, 32'd64);
        #2;
        chk("sw_en", 160'(dispatch_en), 160'(4'b1000));
        chk("sw_ldst_opcode", 160'(o_ld_st_fifo_data.ld_st_opcode), 160'(1'b1));
        tick();
        dec_valid = 1'b0;
        #2;
        chk("jal_en", 160'(dispatch_en), 160'(4'b0000));
        chk("jal_rdy", 160'(dec_ready), 160'(1'b1));
        tick();

        // Flush a held LW while the branch FSM is blocking
        offer(BRANCH_TYPE, 3'd1, 7'd0, 5'd1, 5'd2, 7'h01, 7'h02, 32'd16);
        tick();
        offer(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 7'h01, 7'h02, 32'd0);
        repeat (2) tick();
        offer(LOAD_TYPE, 3'd2, 7'd0, 5'd1, 5'd0, 7'h01, 7'h00, 32'd4);
        tick();
        dec_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #2;
        chk("flush_en", 160'(dispatch_en), 160'(4'b0000));
        chk("flush_rdy", 160'(dec_ready), 160'(1'b1));
        tick();

        // Reset in the middle of a full-queue stall
        queue_full = 4'b0010;
        offer(R_TYPE, 3'd0, 7'd1, 5'd3, 5'd4, 7'h01, 7'h02, 32'd0);
        tick();
        dec_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_rdy", 160'(dec_ready), 160'(1'b0));
        chk("rst_mid_en", 160'(dispatch_en), 160'(4'b0000));
        chk("rst_mid_int", 160'(o_int_fifo_data), 160'(0));
        chk("rst_mid_mult", 160'(o_mult_fifo_data), 160'(0));
        chk("rst_mid_div", 160'(o_div_fifo_data), 160'(0));
        chk("rst_mid_ldst", 160'(o_ld_st_fifo_data), 160'(0));
        rst = 1'b0;
        queue_full = 4'b0000;
        tick();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            dec_valid = ($urandom_range(0, 9) < 7);
            opcode    = op_tab[$urandom_range(0, 10)];
            func3     = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       func7 = 7'd1;
                1:       func7 = 7'h20;
                default: func7 = 7'd0;
            endcase
            rs1       = 5'($urandom_range(0, 3));
            rs2       = 5'($urandom_range(0, 3));
            rs1_tag   = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 7))};
            rs2_tag   = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 7))};
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            immediate = $urandom;
            rd_tag    = 6'($urandom);
            cdb_valid = 2'($urandom);
            cdb_tag   = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            cdb_data  = {$urandom, $urandom};
            for (int q = 0; q < 4; q++) queue_full[q] = ($urandom_range(0, 3) == 0);
            br_resolved = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
